dm_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port data memory (DM) between the processing cores of the multi-core multiplier. Each core raises a request carrying address, write flag and write data. The arbiter grants one core at a time, drives the DM port, and returns read data with a per-core valid strobe. It sits between the cores' DM-access stage and the DM block that feeds the `dm` input of each core's bus.

---
 rtl/dm_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing the single-port data memory (DM)
// between the cores of the multi-core multiplier.
//
// A request is sampled only while idle. The winner's index, write flag, address
// and write data are latched. The DM port is then driven from those latched
// values until the access finishes with a one-cycle `done` pulse to the owner.
//
// Parameters:
//   N_CORES  number of requesting cores (2..8)
//   ADDR_W   DM address width
//   DATA_W   DM data width
//
// Ports:
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset
//   req        per-core level request, held until the core sees its done bit
//   we         per-core write flag, valid while req is high
//   addr       packed per-core addresses, core i at [i*ADDR_W +: ADDR_W]
//   wdata      packed per-core write data, core i at [i*DATA_W +: DATA_W]
//   grant      one-hot owner of the DM port
//   done       one-cycle completion pulse to the owner
//   rdata      registered read data, valid with done for reads; held otherwise
//   mem_addr   DM address
//   mem_wdata  DM write data
//   mem_we     DM write enable, high for one cycle per write
//   mem_rdata  DM read data, valid one cycle after the address is presented
//
// Build option:
//   DM_ARB_PRIO_EN  when defined, core 0 has fixed top priority. Grants to
//                   core 0 do not move the round-robin pointer. The other
//                   cores share the remaining slots round-robin.

module dm_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        grant,
  output logic [N_CORES-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned NC    = N_CORES;
  localparam int unsigned IDX_W = $clog2(N_CORES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;        // most recent round-robin winner
  logic [IDX_W-1:0] win_q;       // owner of the current access
  logic             we_q;        // latched write flag of the owner
  logic [IDX_W-1:0] pick;        // combinational winner, valid in S_IDLE
  logic             pick_valid;
  int unsigned      cand;

  function automatic logic [N_CORES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search. It starts one past the last winner and wraps, so the
  // last winner is considered only after every other core.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = 0;
    for (int unsigned off = 1; off <= NC; off++) begin
      cand = (32'(last) + off) % NC;
      if (!pick_valid && req[IDX_W'(cand)]) begin
        pick       = IDX_W'(cand);
        pick_valid = 1'b1;
      end
    end
`ifdef DM_ARB_PRIO_EN
    // Core 0 overrides the rotation. The pointer is untouched, so the other
    // cores resume their rotation where they left off.
    if (req[0]) begin
      pick       = '0;
      pick_valid = 1'b1;
    end
`endif
  end

  // The DM port outputs are loaded at grant time and then held. This drives
  // the latched values throughout ACCESS. mem_we is cleared on leaving
  // ACCESS, so it is high for exactly one cycle per write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      last      <= IDX_W'(N_CORES - 1);
      win_q     <= '0;
      we_q      <= 1'b0;
      grant     <= '0;
      done      <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            win_q     <= pick;
            we_q      <= we[pick];
            mem_addr  <= addr[pick*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[pick*DATA_W +: DATA_W];
            mem_we    <= we[pick];
            grant     <= onehot(pick);
            state     <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          mem_we <= 1'b0;
          if (we_q) begin
            done  <= onehot(win_q);
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          rdata <= mem_rdata;
          done  <= onehot(win_q);
          state <= S_DONE;
        end

        S_DONE: begin
          done  <= '0;
          grant <= '0;
`ifdef DM_ARB_PRIO_EN
          if (win_q != '0) begin
            last <= win_q;
          end
`else
          last  <= win_q;
`endif
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter (N_CORES=4, 8-bit address and data).
// A behavioural DM array sits on the memory port. A reference memory and a
// round-robin pointer model provide every expected value.

module tb_dm_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic [DW-1:0]   mem_rdata;

  always #5 clk = ~clk;

  dm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant), .done(done), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // DM with one-cycle read latency, plus a back-door preload port
  logic [DW-1:0] dm_mem [0:255];
  logic          pre_we;
  logic [7:0]    pre_addr, pre_data;

  always @(posedge clk) begin
    if (pre_we) dm_mem[pre_addr] <= pre_data;
    else if (mem_we) dm_mem[mem_addr] <= mem_wdata;
    mem_rdata <= dm_mem[mem_addr];
  end

  // Reference model
  logic [7:0] ref_mem [0:255];
  logic [7:0] exp_rdata;
  int         m_last;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic int model_pick(input logic [N-1:0] pend);
`ifdef DM_ARB_PRIO_EN
    if (pend[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_commit(input int w);
`ifdef DM_ARB_PRIO_EN
    if (w == 0) return;
`endif
    m_last = w;
  endtask

  // One isolated access by a single core with full timing checks
  task automatic do_access(input int core, input logic w, input logic [7:0] a,
                           input logic [7:0] d);
    int cyc;
    int we_cnt;
    logic [N-1:0] exp_g;
    exp_g = N'(1) << model_pick(N'(1) << core);
    req[core] = 1'b1;
    we[core]  = w;
    addr[core*AW +: AW]  = a;
    wdata[core*DW +: DW] = d;
    @(negedge clk);
    cyc = 0;
    while (grant === '0 && cyc < 8) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc != 0 || grant !== exp_g) begin
      n_err++;
      $display("FAIL grant c%0d: got %b after %0d extra cycles, expected %b next cycle", core, grant, cyc, exp_g);
    end
    n_cmp++;
    if (mem_addr !== a || (w && mem_wdata !== d)) begin
      n_err++;
      $display("FAIL port c%0d: mem_addr=%h mem_wdata=%h expected %h/%h", core, mem_addr, mem_wdata, a, d);
    end
    we_cnt = 0;
    cyc = 0;
    while (done === '0 && cyc < 8) begin
      if (mem_we === 1'b1) we_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (mem_we === 1'b1) we_cnt++;
    n_cmp++;
    if (cyc != (w ? 1 : 2) || done !== exp_g) begin
      n_err++;
      $display("FAIL done c%0d: done=%b after %0d cycles, expected %b after %0d", core, done, cyc, exp_g, (w ? 1 : 2));
    end
    n_cmp++;
    if (we_cnt != (w ? 1 : 0)) begin
      n_err++;
      $display("FAIL mem_we_cycles c%0d: got %0d expected %0d", core, we_cnt, (w ? 1 : 0));
    end
    if (w) ref_mem[a] = d;
    else exp_rdata = ref_mem[a];
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL rdata c%0d a=%h: got %h expected %h", core, a, rdata, exp_rdata);
    end
    req[core] = 1'b0;
    model_commit(model_pick(N'(1) << core));
    @(negedge clk);
    n_cmp++;
    if (grant !== '0 || done !== '0) begin
      n_err++;
      $display("FAIL release c%0d: grant=%b done=%b expected 0/0", core, grant, done);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 8'(a); pre_data = 8'(a * 37 + 11);
      ref_mem[a] = 8'(a * 37 + 11);
    end
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 8'h10; pre_data = 8'hA5; ref_mem[8'h10] = 8'hA5;
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    m_last = N - 1;
    exp_rdata = '0;
    n_cmp++;
    if (grant !== '0 || done !== '0 || mem_we !== 1'b0 || rdata !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset: grant=%b done=%b we=%b rdata=%h addr=%h wdata=%h expected all 0",
               grant, done, mem_we, rdata, mem_addr, mem_wdata);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int cyc;
    int e;
    req = '1; we = '0;
    for (int c = 0; c < N; c++) addr[c*AW +: AW] = 8'(8'h80 + c);
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      while (grant === '0 && cyc < 10) begin @(negedge clk); cyc++; end
      e = model_pick(req);
      n_cmp++;
      if (grant !== (N'(1) << e)) begin
        n_err++;
        $display("FAIL rr_order grant %0d: got %b expected %b", g, grant, N'(1) << e);
      end
      cyc = 0;
      while (done === '0 && cyc < 10) begin @(negedge clk); cyc++; end
      exp_rdata = ref_mem[8'h80 + e];
      n_cmp++;
      if (done !== (N'(1) << e) || rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL rr_done %0d: done=%b rdata=%h expected %b/%h", g, done, rdata, N'(1) << e, exp_rdata);
      end
      model_commit(e);
      if (g == 4) req = '0;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_change_drop;
    int cyc;
    int regrants;
    req[1] = 1'b1; we[1] = 1'b0; addr[1*AW +: AW] = 8'h05;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0010) begin
      n_err++;
      $display("FAIL chg_grant: got %b expected 0010", grant);
    end
    addr[1*AW +: AW] = 8'h06;
    req[1] = 1'b0;
    n_cmp++;
    if (mem_addr !== 8'h05) begin
      n_err++;
      $display("FAIL chg_addr: mem_addr=%h expected 05", mem_addr);
    end
    cyc = 0;
    while (done === '0 && cyc < 8) begin @(negedge clk); cyc++; end
    exp_rdata = ref_mem[8'h05];
    n_cmp++;
    if (done !== 4'b0010 || rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL chg_done: done=%b rdata=%h expected 0010/%h", done, rdata, exp_rdata);
    end
    model_commit(1);
    regrants = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (grant !== '0) regrants++;
    end
    n_cmp++;
    if (regrants != 0) begin
      n_err++;
      $display("FAIL no_regrant: grant seen in %0d cycles expected 0", regrants);
    end
  endtask

  task automatic test_reset_in_wait;
    int dones;
    req[3] = 1'b1; we[3] = 1'b0; addr[3*AW +: AW] = 8'h44;
    @(negedge clk);   // ACCESS
    @(negedge clk);   // WAIT
    rstn = 1'b0;
    req = '0;
    @(negedge clk);
    m_last = N - 1;
    exp_rdata = '0;
    n_cmp++;
    if (grant !== '0 || done !== '0 || rdata !== '0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL abort: grant=%b done=%b rdata=%h we=%b expected 0", grant, done, rdata, mem_we);
    end
    rstn = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== '0 || grant !== '0) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL abort_quiet: activity in %0d cycles expected 0", dones);
    end
    do_access(3, 1'b0, 8'h44, 8'h00);
  endtask

  task automatic test_random;
    logic [N-1:0] pend;
    logic [7:0]   ra [N];
    logic [7:0]   rd [N];
    logic         rw [N];
    int cyc;
    int e;
    for (int r = 0; r < 25; r++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < N; c++) begin
        rw[c] = 1'($urandom);
        ra[c] = 8'($urandom);
        rd[c] = 8'($urandom);
        we[c] = rw[c];
        addr[c*AW +: AW]  = ra[c];
        wdata[c*DW +: DW] = rd[c];
      end
      req = pend;
      for (int k = 0; k < N && pend != '0; k++) begin
        cyc = 0;
        while (grant === '0 && cyc < 10) begin @(negedge clk); cyc++; end
        e = model_pick(pend);
        n_cmp++;
        if (grant !== (N'(1) << e)) begin
          n_err++;
          $display("FAIL rand_grant r%0d: got %b expected %b pend=%b", r, grant, N'(1) << e, pend);
        end
        cyc = 0;
        while (done === '0 && cyc < 10) begin @(negedge clk); cyc++; end
        if (rw[e]) ref_mem[ra[e]] = rd[e];
        else exp_rdata = ref_mem[ra[e]];
        n_cmp++;
        if (done !== (N'(1) << e) || rdata !== exp_rdata) begin
          n_err++;
          $display("FAIL rand_done r%0d c%0d w=%0b a=%h: done=%b rdata=%h expected %b/%h",
                   r, e, rw[e], ra[e], done, rdata, N'(1) << e, exp_rdata);
        end
        req[e]  = 1'b0;
        pend[e] = 1'b0;
        model_commit(e);
        @(negedge clk);
      end
      req = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    m_last = N - 1;
    exp_rdata = '0;
    test_reset;
    test_round_robin;
    do_access(2, 1'b0, 8'h10, 8'h00);   // single read, expect A5
    do_access(1, 1'b1, 8'h20, 8'h3C);   // single write
    do_access(0, 1'b0, 8'h20, 8'h00);   // read back 3C
    test_addr_change_drop;
    test_reset_in_wait;
    do_access(2, 1'b0, 8'hFF, 8'h00);   // address extremes
    do_access(1, 1'b1, 8'h00, 8'h5A);
    do_access(0, 1'b0, 8'hFF, 8'h00);
    do_access(3, 1'b0, 8'h00, 8'h00);
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
